fp_comp_pipe: RTL and testbench
===============================

// Module: fp_comp_pipe
// PURPOSE
//  Parametrised FloPoCo-format FP comparator / min-max unit with valid/ready handshake.
//  Supports any exponent/fraction width and 0..4 pipeline stages with full backpressure.
//  Outputs ordered-compare flags plus a selected min/max result.
//  Sits in the FP datapath beside the add/mul operators; drop-in for stream-style pipelines.
// PARAMETERS
//  WE          8   exponent width
//  WF          23  fraction width; operand width W = WE+WF+3 ({exn[1:0],sign,exp,frac})
//  NUM_STAGES  1   pipeline depth 0..4; any other value is an elaboration $error
//  CNT_W       16  unordered-counter width (FP_COMP_STATUS_EN only)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   operands valid
//  in_ready    out  1   unit accepts operands this cycle
//  X, Y        in   W   operands, FloPoCo format
//  sel_max     in   1   0: R=min(X,Y), 1: R=max(X,Y)
//  out_valid   out  1   result valid
//  out_ready   in   1   downstream accepts result
//  unordered   out  1   X or Y is NaN
//  XltY/XeqY/XleY out 1 each  ordered-compare flags, all 0 when unordered
//  R           out  W   min/max result
//  clr_status  in   1   (FP_COMP_STATUS_EN) clear status
//  nan_seen    out  1   (FP_COMP_STATUS_EN) sticky: a NaN operand completed
//  unord_cnt   out CNT_W (FP_COMP_STATUS_EN) saturating count of unordered results
// BEHAVIOUR
//  - exn: 00 zero, 01 normal, 10 inf, 11 NaN; exn=00/10/11 ignore exp/frac.
//  - Equality: +0==-0; inf equal iff same sign; normals equal iff sign,exp,frac equal.
//  - Order: -inf < -normal < zero < +normal < +inf; normals by {exp,frac}, inverted when negative.
//  - XleY = XltY|XeqY. Any NaN: unordered=1, the other three flags 0.
//  - R: one NaN returns the other operand; both NaN returns {2'b11, all-zero}.
//    Equal zeros: min returns -0 if either is -0; max returns +0 if either is +0.
//    Otherwise R equals the selected operand bit-exactly, X preferred on ties.
//  - NUM_STAGES=0: fully combinational; in_ready=out_ready, out_valid=in_valid.
//  - NUM_STAGES=N>=1: all compare logic before stage 1; stages 2..N are pure delay regs.
//    Each stage has a valid bit; ready_i = !valid_i | ready_{i+1}, so bubbles collapse.
//    in_ready = ready_1; ready_{N+1} = out_ready. Latency N cycles. Throughput 1/cycle.
//  - Data held stable while out_valid & !out_ready; no drop, no duplicate.
//  - Reset: all stage valid bits 0, out_valid 0, flags 0, R 0, nan_seen 0, unord_cnt 0.
//    Reset mid-stream discards in-flight items; in_ready = 1 after reset for N>=1.
//  - Data regs load only when their stage advances (valid & ready).
// CONFIGURATION
//  FP_COMP_STATUS_EN defined: status ports present. On each output handshake with unordered=1:
//    nan_seen<=1 and unord_cnt++ (saturating at all-ones).
//    clr_status zeroes both and takes precedence over a same-cycle event (event lost).
//  Not defined: status ports and regs absent; no status logic.
// STRUCTURE
//  fp_comp_pkg: exn_e enum (EXN_ZERO/NORMAL/INF/NAN), field-slice functions for exn/sign/exp/frac
//    parametrised by WE/WF, canonical-NaN constant function.
//  fp_comp_core: combinational sub-module (flags + R).
//  fp_comp_pipe: handshake stage chain + optional status.
// TESTING (WE=8, WF=23, NUM_STAGES=2 unless noted)
//  1) X=1.0 (01,0,7F,0), Y=2.0 (01,0,80,0), sel_max=0 -> XltY=1,XleY=1,XeqY=0,R=X after 2 cycles.
//  2) X=+0, Y=-0, sel_max=1 -> XeqY=1,XleY=1,R=+0; sel_max=0 -> R=-0.
//  3) X=NaN, Y=-inf -> unordered=1, other flags 0, R=-inf; both NaN -> R={2'b11,0}.
//  4) Stream 8 back-to-back ops, out_ready low 3 cycles mid-stream -> 8 results in order, none lost.
//  5) Reset asserted with 2 items in flight -> out_valid=0 at once; no stale output after release.
//  6) FP_COMP_STATUS_EN, CNT_W=2: 5 NaN ops -> unord_cnt=3 saturated, nan_seen=1;
//     clr_status with a NaN completion in the same cycle -> both 0.

Source files
------------

// File: rtl/fp_comp_pkg.sv
// Shared types and field helpers for the FloPoCo-format comparator.
// Operand layout is {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
package fp_comp_pkg;

    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_e;

    function automatic int exn_lsb(input int we, input int wf);
        return we + wf + 1;
    endfunction

    function automatic int sign_bit(input int we, input int wf);
        return we + wf;
    endfunction

    function automatic int exp_lsb(input int we, input int wf);
        return (we >= 0) ? wf : 0;
    endfunction

    function automatic int frac_lsb(input int we, input int wf);
        return (we >= 0 && wf >= 0) ? 0 : 0;
    endfunction

    function automatic logic [MAX_W-1:0] canon_nan(input int we, input int wf);
        logic [MAX_W-1:0] v;
        v = '0;
        v[we+wf+1 +: 2] = 2'b11;
        return v;
    endfunction

    // Total order over non-NaN classes: -inf < -normal < zero < +normal < +inf.
    function automatic logic [2:0] order_class(input exn_e e, input logic s);
        logic [2:0] c;
        c = 3'd2;
        case (e)
            EXN_NORMAL: c = s ? 3'd1 : 3'd3;
            EXN_INF:    c = s ? 3'd0 : 3'd4;
            default:    c = 3'd2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fp_comp_core.sv
// Combinational compare flags and min/max selection for two FloPoCo operands.
module fp_comp_core
    import fp_comp_pkg::*;
#(
    parameter int WE = 8,
    parameter int WF = 23
) (
    input  logic [WE+WF+2:0] x,
    input  logic [WE+WF+2:0] y,
    input  logic             sel_max,
    output logic             unordered,
    output logic             xlty,
    output logic             xeqy,
    output logic             xley,
    output logic [WE+WF+2:0] r
);

    localparam int W        = WE + WF + 3;
    localparam int EXN_LSB  = exn_lsb(WE, WF);
    localparam int SIGN_POS = sign_bit(WE, WF);
    localparam int MAG_LSB  = frac_lsb(WE, WF);
    localparam logic [W-1:0] NAN_R = W'(canon_nan(WE, WF));

    exn_e             xe, ye;
    logic             xs, ys;
    logic [WE+WF-1:0] xmag, ymag;
    logic [2:0]       xc, yc;
    logic             x_nan, y_nan;

    assign xe    = exn_e'(x[EXN_LSB +: 2]);
    assign ye    = exn_e'(y[EXN_LSB +: 2]);
    assign xs    = x[SIGN_POS];
    assign ys    = y[SIGN_POS];
    assign xmag  = x[SIGN_POS-1:MAG_LSB];
    assign ymag  = y[SIGN_POS-1:MAG_LSB];
    assign xc    = order_class(xe, xs);
    assign yc    = order_class(ye, ys);
    assign x_nan = (xe == EXN_NAN);
    assign y_nan = (ye == EXN_NAN);

    // Within one class only normals need a magnitude compare; negatives invert it.
    always_comb begin
        unordered = x_nan | y_nan;
        xeqy      = 1'b0;
        xlty      = 1'b0;
        if (!unordered) begin
            if (xc == yc) begin
                xeqy = (xc != 3'd1 && xc != 3'd3) || (xmag == ymag);
                xlty = (xc == 3'd3 && xmag < ymag) || (xc == 3'd1 && xmag > ymag);
            end else begin
                xlty = (xc < yc);
            end
        end
        xley = xlty | xeqy;
    end

    always_comb begin
        r = x;
        if (x_nan && y_nan) begin
            r = NAN_R;
        end else if (x_nan) begin
            r = y;
        end else if (y_nan) begin
            r = x;
        end else if (xe == EXN_ZERO && ye == EXN_ZERO) begin
            if (sel_max) r = (xs && !ys) ? y : x;
            else         r = (!xs && ys) ? y : x;
        end else if (sel_max) begin
            r = xlty ? y : x;
        end else begin
            r = xley ? x : y;
        end
    end

endmodule

// File: rtl/fp_comp_pipe.sv
// Pipelined FP comparator / min-max with valid-ready handshake (0..4 stages).
// Optional status counters are enabled with the FP_COMP_STATUS_EN macro.
module fp_comp_pipe
    import fp_comp_pkg::*;
#(
    parameter int WE         = 8,
    parameter int WF         = 23,
    parameter int NUM_STAGES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WE+WF+2:0] X,
    input  logic [WE+WF+2:0] Y,
    input  logic             sel_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             unordered,
    output logic             XltY,
    output logic             XeqY,
    output logic             XleY,
    output logic [WE+WF+2:0] R
`ifdef FP_COMP_STATUS_EN
    ,
    input  logic             clr_status,
    output logic             nan_seen,
    output logic [CNT_W-1:0] unord_cnt
`endif
);

    localparam int W  = WE + WF + 3;
    localparam int DW = W + 4;

    logic [DW-1:0] core_d;
    logic          c_unord, c_lt, c_eq, c_le;
    logic [W-1:0]  c_r;

    fp_comp_core #(.WE(WE), .WF(WF)) u_core (
        .x         (X),
        .y         (Y),
        .sel_max   (sel_max),
        .unordered (c_unord),
        .xlty      (c_lt),
        .xeqy      (c_eq),
        .xley      (c_le),
        .r         (c_r)
    );

    assign core_d = {c_unord, c_lt, c_eq, c_le, c_r};

    if (NUM_STAGES < 0 || NUM_STAGES > 4 || CNT_W < 1) begin : g_bad_cfg
        $error("fp_comp_pipe: NUM_STAGES must be 0..4 and CNT_W >= 1");
    end

    if (NUM_STAGES == 0) begin : g_comb
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign {unordered, XltY, XeqY, XleY, R} = core_d;
    end else begin : g_pipe
        localparam int N = NUM_STAGES;

        logic [N:1]         sv;
        logic [N:1]         pv;
        logic [N:1]         rdy;
        logic [N:1][DW-1:0] sd;
        logic [N:1][DW-1:0] pd;

        // Ready ripples backward from the output; an empty stage always accepts.
        always_comb begin
            logic r;
            r   = out_ready;
            rdy = '0;
            for (int i = N; i >= 1; i--) begin
                r      = !sv[i] | r;
                rdy[i] = r;
            end
        end

        always_comb begin
            pv    = '0;
            pd    = '0;
            pv[1] = in_valid;
            pd[1] = core_d;
            for (int i = 2; i <= N; i++) begin
                pv[i] = sv[i-1];
                pd[i] = sd[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sv <= '0;
                sd <= '0;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    if (rdy[i]) sv[i] <= pv[i];
                    if (rdy[i] && pv[i]) sd[i] <= pd[i];
                end
            end
        end

        assign in_ready  = rdy[1];
        assign out_valid = sv[N];
        assign {unordered, XltY, XeqY, XleY, R} = sd[N];
    end

`ifdef FP_COMP_STATUS_EN
    // A clear wins over a same-cycle unordered completion, which is then lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen  <= 1'b0;
            unord_cnt <= '0;
        end else if (clr_status) begin
            nan_seen  <= 1'b0;
            unord_cnt <= '0;
        end else if (out_valid && out_ready && unordered) begin
            nan_seen <= 1'b1;
            if (unord_cnt != {CNT_W{1'b1}}) unord_cnt <= unord_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fp_comp_pipe.sv
// Directed self-checking bench for fp_comp_pipe (WE=8, WF=23, NUM_STAGES=2).
// Status checks are compiled only when FP_COMP_STATUS_EN is defined.
module tb_fp_comp_pipe;

    localparam int WE = 8;
    localparam int WF = 23;
    localparam int W  = WE + WF + 3;
    localparam int NS = 2;
`ifdef FP_COMP_STATUS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X, Y;
    logic         sel_max;
    logic         out_valid;
    logic         out_ready;
    logic         unordered, XltY, XeqY, XleY;
    logic [W-1:0] R;
`ifdef FP_COMP_STATUS_EN
    logic             clr_status;
    logic             nan_seen;
    logic [CNT_W-1:0] unord_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0]   obs_flags;
    logic [W-1:0] obs_r;
    int           obs_lat;

    fp_comp_pipe #(.WE(WE), .WF(WF), .NUM_STAGES(NS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .X          (X),
        .Y          (Y),
        .sel_max    (sel_max),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .unordered  (unordered),
        .XltY       (XltY),
        .XeqY       (XeqY),
        .XleY       (XleY),
        .R          (R)
`ifdef FP_COMP_STATUS_EN
        ,
        .clr_status (clr_status),
        .nan_seen   (nan_seen),
        .unord_cnt  (unord_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s,
                                        input logic [7:0] ex, input logic [22:0] fr);
        return {e, s, ex, fr};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sends one operand pair into an idle pipe and waits for its result.
    task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sm);
        @(negedge clk);
        X = xv; Y = yv; sel_max = sm; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        obs_lat = 1;
        while (!out_valid && obs_lat < 10) begin
            @(negedge clk);
            obs_lat++;
        end
        checkOutput("result_valid", {63'd0, out_valid}, 64'd1);
        obs_flags = {unordered, XltY, XeqY, XleY};
        obs_r     = R;
        @(negedge clk);
    endtask

    logic [W-1:0] one_p, two_p, one_n, two_n, zero_p, zero_n, inf_p, inf_n, nan_a, nan_b;
    logic [W-1:0] exp_r [8];
    int got;
    int stray;

    initial begin
        one_p  = mk(2'b01, 1'b0, 8'h7F, 23'h0);
        two_p  = mk(2'b01, 1'b0, 8'h80, 23'h0);
        one_n  = mk(2'b01, 1'b1, 8'h7F, 23'h0);
        two_n  = mk(2'b01, 1'b1, 8'h80, 23'h0);
        zero_p = mk(2'b00, 1'b0, 8'h00, 23'h0);
        zero_n = mk(2'b00, 1'b1, 8'h00, 23'h0);
        inf_p  = mk(2'b10, 1'b0, 8'h00, 23'h0);
        inf_n  = mk(2'b10, 1'b1, 8'h00, 23'h0);
        nan_a  = mk(2'b11, 1'b0, 8'h00, 23'h5);
        nan_b  = mk(2'b11, 1'b1, 8'h03, 23'h7);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel_max = 1'b0;
        X = '0; Y = '0;
`ifdef FP_COMP_STATUS_EN
        clr_status = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_flags", {60'd0, unordered, XltY, XeqY, XleY}, 64'd0);
        checkOutput("reset_r", 64'(R), 64'd0);
        rst_n = 1'b1;
        checkOutput("reset_ready", {63'd0, in_ready}, 64'd1);

        // flags order: {unordered, lt, eq, le}
        applyStimulus(one_p, two_p, 1'b0);
        checkOutput("lt_flags", 64'(obs_flags), 64'h5);
        checkOutput("lt_min_r", 64'(obs_r), 64'(one_p));
        checkOutput("latency", 64'(obs_lat), 64'd2);
        applyStimulus(one_p, two_p, 1'b1);
        checkOutput("lt_max_r", 64'(obs_r), 64'(two_p));

        applyStimulus(zero_p, zero_n, 1'b1);
        checkOutput("zero_flags", 64'(obs_flags), 64'h3);
        checkOutput("zero_max_r", 64'(obs_r), 64'(zero_p));
        applyStimulus(zero_p, zero_n, 1'b0);
        checkOutput("zero_min_r", 64'(obs_r), 64'(zero_n));

        applyStimulus(nan_a, inf_n, 1'b0);
        checkOutput("nan_flags", 64'(obs_flags), 64'h8);
        checkOutput("nan_r", 64'(obs_r), 64'(inf_n));
        applyStimulus(nan_a, nan_b, 1'b1);
        checkOutput("nan2_r", 64'(obs_r), 64'h3_0000_0000);

        applyStimulus(two_n, one_n, 1'b1);
        checkOutput("neg_flags", 64'(obs_flags), 64'h5);
        checkOutput("neg_max_r", 64'(obs_r), 64'(one_n));
        applyStimulus(inf_p, two_p, 1'b1);
        checkOutput("inf_flags", 64'(obs_flags), 64'h0);
        checkOutput("inf_max_r", 64'(obs_r), 64'(inf_p));
        applyStimulus(inf_n, inf_n, 1'b0);
        checkOutput("inf_eq_flags", 64'(obs_flags), 64'h3);

        // Streaming with a mid-stream stall; max against 1.0 always returns X.
        for (int i = 0; i < 8; i++) exp_r[i] = mk(2'b01, 1'b0, 8'h80 + 8'(i), 23'h0);
        got = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int guard;
                    @(negedge clk);
                    X = exp_r[i]; Y = one_p; sel_max = 1'b1; in_valid = 1'b1;
                    #1;
                    guard = 0;
                    while (!in_ready && guard < 50) begin
                        @(negedge clk);
                        #1;
                        guard++;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60 && got < 8; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 4 && c < 7);
                    #2;
                    if (out_valid && out_ready) begin
                        checkOutput("stream_r", 64'(R), 64'(exp_r[got]));
                        got++;
                    end
                end
            end
        join
        checkOutput("stream_cnt", 64'(got), 64'd8);
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("stream_drain", {63'd0, out_valid}, 64'd0);

        // Reset with two items held in the pipe.
        out_ready = 1'b0;
        @(negedge clk);
        X = one_p; Y = two_p; sel_max = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        X = two_p;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("prereset_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_r", 64'(R), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        checkOutput("postreset_ready", {63'd0, in_ready}, 64'd1);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("postreset_stale", 64'(stray), 64'd0);

`ifdef FP_COMP_STATUS_EN
        repeat (5) applyStimulus(nan_a, one_p, 1'b0);
        checkOutput("stat_cnt_sat", 64'(unord_cnt), 64'd3);
        checkOutput("stat_nan_seen", {63'd0, nan_seen}, 64'd1);
        out_ready = 1'b0;
        @(negedge clk);
        X = nan_a; Y = nan_b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stat_pending", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        checkOutput("stat_clr_cnt", 64'(unord_cnt), 64'd0);
        checkOutput("stat_clr_seen", {63'd0, nan_seen}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
